// File: rtl/core_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_sequencer                                               |
// | Description : Multi-cycle control FSM for the BeeF core. Fetches one       |
// |               9-bit instruction and sequences decode, data-memory read,    |
// |               execute and write-back. Owns the program counter and         |
// |               resolves the CBF branch.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module core_sequencer #(
    parameter int         PC_WIDTH   = 8,
    // CBF is identified by the top three instruction bits.
    parameter logic [2:0] CBF_OPCODE = 3'b111
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                halt_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_valid,
    input  logic [8:0]          imem_data,
    output logic [8:0]          instr,
    input  logic [2:0]          address_select,
    input  logic [2:0]          alu_select,
    output logic [2:0]          addr_sel,
    output logic [2:0]          alu_sel,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    input  logic                cell_zero,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                alu_en,
    output logic                retire,
    output logic                busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic                load_instr;
    logic                load_sel;
    logic                is_cbf;

    assign imem_addr = pc;
    assign busy      = (state != ST_IDLE);
    assign is_cbf    = (instr[8:6] == CBF_OPCODE);

    // State, program counter and instruction/select registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            instr    <= '0;
            addr_sel <= '0;
            alu_sel  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load_instr) begin
                instr <= imem_data;
            end
            if (load_sel) begin
                addr_sel <= address_select;
                alu_sel  <= alu_select;
            end
        end
    end

    // Next-state, program-counter update and request/strobe outputs.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_instr = 1'b0;
        load_sel   = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_en     = 1'b0;
        retire     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    load_instr = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                load_sel   = 1'b1;
                // Only INC/DEC, MVR/MVL and PSH/POP need the current cell.
                state_next = (alu_select <= 3'd2) ? ST_MEM : ST_EXEC;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_en = 1'b1;
                case (alu_sel)
                    3'd0, 3'd2: begin
                        state_next = ST_WB;
                    end
                    3'd3: begin
                        retire  = 1'b1;
                        pc_next = (is_cbf && cell_zero) ? branch_target : pc + PC_STEP;
                    end
                    default: begin
                        // MVR/MVL and the NOP group just advance.
                        retire  = 1'b1;
                        pc_next = pc + PC_STEP;
                    end
                endcase
            end
            ST_WB: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                if (dmem_ready) begin
                    retire  = 1'b1;
                    pc_next = pc + PC_STEP;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Every retiring path chooses between stopping and the next fetch.
        if (retire) begin
            state_next = halt_req ? ST_IDLE : ST_FETCH;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_core_sequencer                                            |
// | Description : Randomized scoreboard bench for core_sequencer. The driver   |
// |               acts as instruction/data memory and decoder; each delivered  |
// |               instruction pushes its expected retirement into a queue      |
// |               that a separate monitor pops on every retire pulse.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_core_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       halt_req;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_valid;
    logic [8:0] imem_data;
    logic [8:0] instr;
    logic [2:0] address_select;
    logic [2:0] alu_select;
    logic [2:0] addr_sel;
    logic [2:0] alu_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;
    logic       cell_zero;
    logic [7:0] branch_target;
    logic       alu_en;
    logic       retire;
    logic       busy;

    core_sequencer #(.PC_WIDTH(8), .CBF_OPCODE(3'b111)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_valid     (imem_valid),
        .imem_data      (imem_data),
        .instr          (instr),
        .address_select (address_select),
        .alu_select     (alu_select),
        .addr_sel       (addr_sel),
        .alu_sel        (alu_sel),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_ready     (dmem_ready),
        .cell_zero      (cell_zero),
        .branch_target  (branch_target),
        .alu_en         (alu_en),
        .retire         (retire),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Program memory and per-address branch table.
    logic [8:0] imem [256];
    logic [7:0] bt   [256];

    // Decoder stand-in: selects are plain instruction fields.
    assign address_select = instr[5:3];
    assign alu_select     = instr[2:0];
    assign branch_target  = bt[imem_addr];

    typedef struct {
        logic [8:0] ins;
        logic [7:0] pc_next;
        int         lat;
        int         reads;
        int         writes;
        bit         halt;
    } exp_t;

    exp_t expq[$];

    int errors    = 0;
    int checks    = 0;
    int n_retired = 0;
    int stop_at   = 32'h7fffffff;
    int idle_wait = 0;
    bit drv_on    = 0;
    bit force_mode = 0;
    bit long_read  = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    function automatic logic [8:0] gen_instr();
        logic [8:0] v;
        if ($urandom_range(0, 3) == 0) begin
            v = {3'b111, 3'($urandom), 3'b011};
        end else begin
            v = 9'($urandom);
        end
        return v;
    endfunction

    // Memory/decoder driver: answers requests and issues expectations.
    initial begin
        bit         fetch_active;
        bit         read_active;
        bit         write_active;
        int         fcnt, fw0, rcnt, wcnt, cur_rw, cur_ww;
        logic [8:0] ins;
        logic [7:0] p;
        logic [2:0] sel;
        bit         cz, hl;
        exp_t       e;
        fetch_active = 0; read_active = 0; write_active = 0;
        fcnt = 0; fw0 = 0; rcnt = 0; wcnt = 0; cur_rw = 0; cur_ww = 0;
        start = 0; halt_req = 0; imem_valid = 0; imem_data = '0;
        dmem_ready = 0; cell_zero = 0;
        forever begin
            @(posedge clock);
            #1;
            start      = 0;
            imem_valid = 0;
            dmem_ready = 0;
            if (!drv_on || reset) begin
                fetch_active = 0;
                read_active  = 0;
                write_active = 0;
            end else begin
                if (!busy) begin
                    if (idle_wait > 0) idle_wait--;
                    else if (n_retired < stop_at) start = 1;
                end
                if (imem_req) begin
                    if (!fetch_active) begin
                        fetch_active = 1;
                        fcnt = rand_wait();
                        fw0  = fcnt;
                    end
                    if (fcnt == 0) begin
                        fetch_active = 0;
                        p   = imem_addr;
                        ins = imem[p];
                        imem_data  = ins;
                        imem_valid = 1;
                        cz = force_mode ? 1'b1 : 1'($urandom_range(0, 1));
                        hl = force_mode ? (p == 8'hFF) : ($urandom_range(0, 7) == 0);
                        cell_zero = cz;
                        halt_req  = hl;
                        cur_rw = long_read ? 6 : rand_wait();
                        cur_ww = rand_wait();
                        sel = ins[2:0];
                        e.ins    = ins;
                        e.halt   = hl;
                        e.reads  = (sel <= 3'd2) ? 1 : 0;
                        e.writes = (sel == 3'd0 || sel == 3'd2) ? 1 : 0;
                        e.lat    = (fw0 + 1) + 1 + (e.reads != 0 ? cur_rw + 1 : 0)
                                 + 1 + (e.writes != 0 ? cur_ww + 1 : 0);
                        if (sel == 3'd3 && ins[8:6] == 3'b111 && cz) e.pc_next = bt[p];
                        else e.pc_next = p + 8'd1;
                        expq.push_back(e);
                        if (hl) idle_wait = $urandom_range(0, 3);
                    end else begin
                        fcnt--;
                        imem_data = 9'($urandom);
                    end
                end else begin
                    imem_valid = ($urandom_range(0, 3) == 0);
                    imem_data  = 9'($urandom);
                end
                if (dmem_req && !dmem_we) begin
                    if (!read_active) begin read_active = 1; rcnt = cur_rw; end
                    if (rcnt == 0) begin dmem_ready = 1; read_active = 0; end
                    else rcnt--;
                end else if (dmem_req && dmem_we) begin
                    if (!write_active) begin write_active = 1; wcnt = cur_ww; end
                    if (wcnt == 0) begin dmem_ready = 1; write_active = 0; end
                    else wcnt--;
                end else begin
                    dmem_ready = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Monitor: measures each instruction and pops its expectation on retire.
    initial begin
        bit   in_instr;
        bit   chk_pc;
        int   cyc, alu_cnt, rd_cnt, wr_cnt;
        exp_t pend;
        in_instr = 0; chk_pc = 0; cyc = 0; alu_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_instr = 0;
                chk_pc   = 0;
            end else begin
                if (chk_pc) begin
                    chk("pc_after_retire", imem_addr, pend.pc_next);
                    chk("busy_after_retire", busy, pend.halt ? 0 : 1);
                    chk_pc = 0;
                end
                if (!in_instr && imem_req) begin
                    in_instr = 1; cyc = 0; alu_cnt = 0; rd_cnt = 0; wr_cnt = 0;
                end
                if (in_instr) begin
                    cyc++;
                    if (alu_en) alu_cnt++;
                    if (dmem_req && !dmem_we && dmem_ready) rd_cnt++;
                    if (dmem_req && dmem_we && dmem_ready) wr_cnt++;
                    if (retire) begin
                        n_retired++;
                        in_instr = 0;
                        if (expq.size() == 0) begin
                            chk("retire_without_expectation", 1, 0);
                        end else begin
                            pend = expq.pop_front();
                            chk("latency", cyc, pend.lat);
                            chk("alu_en_count", alu_cnt, 1);
                            chk("dmem_reads", rd_cnt, pend.reads);
                            chk("dmem_writes", wr_cnt, pend.writes);
                            chk("instr_reg", instr, pend.ins);
                            chk("addr_sel", addr_sel, pend.ins[5:3]);
                            chk("alu_sel", alu_sel, pend.ins[2:0]);
                            chk_pc = 1;
                        end
                    end else if (cyc > 100) begin
                        chk("instruction_timeout", cyc, 0);
                        in_instr = 0;
                    end
                end else if (retire || alu_en) begin
                    chk("strobe_outside_instruction", 1, 0);
                end
            end
        end
    end

    // Sequencing of the test phases.
    initial begin
        int c;
        reset = 1;
        for (int i = 0; i < 256; i++) begin
            imem[i] = gen_instr();
            bt[i]   = 8'($urandom);
        end
        repeat (3) @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_imem_req", imem_req, 0);
        chk("reset_dmem_req", dmem_req, 0);
        chk("reset_pc", imem_addr, 0);
        chk("reset_instr", instr, 0);
        chk("reset_alu_sel", alu_sel, 0);
        reset = 0;

        // Random program, random memory latencies, random halts.
        drv_on = 1;
        c = 0;
        while (n_retired < 300 && c < 40000) begin @(negedge clock); c++; end
        if (n_retired < 300) chk("random_phase_timeout", n_retired, 300);
        drv_on = 0;
        reset  = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        expq.delete();

        // CBF to 0xFF, then NOP at 0xFF wraps to 0x00 and halts.
        imem[0]     = 9'b111_000_011;
        bt[0]       = 8'hFF;
        imem[8'hFF] = 9'b000_000_100;
        force_mode  = 1;
        idle_wait   = 0;
        stop_at     = n_retired + 2;
        drv_on      = 1;
        c = 0;
        while ((n_retired < stop_at || busy) && c < 200) begin @(negedge clock); c++; end
        @(negedge clock);
        chk("wrap_retired", n_retired, stop_at);
        chk("wrap_pc", imem_addr, 0);
        chk("halt_idle_busy", busy, 0);

        // Reset while a data read is outstanding.
        force_mode = 0;
        long_read  = 1;
        imem[0]    = 9'b000_000_000;
        idle_wait  = 0;
        stop_at    = n_retired + 1;
        c = 0;
        while (!(dmem_req && !dmem_we) && c < 100) begin @(negedge clock); c++; end
        chk("reached_mem_read", dmem_req, 1);
        reset  = 1;
        drv_on = 0;
        @(negedge clock);
        chk("abort_busy", busy, 0);
        chk("abort_dmem_req", dmem_req, 0);
        chk("abort_dmem_we", dmem_we, 0);
        chk("abort_imem_req", imem_req, 0);
        chk("abort_alu_en", alu_en, 0);
        chk("abort_retire", retire, 0);
        chk("abort_pc", imem_addr, 0);
        chk("abort_instr", instr, 0);
        chk("abort_addr_sel", addr_sel, 0);
        reset      = 0;
        dmem_ready = 1;
        imem_valid = 1;
        expq.delete();
        @(negedge clock);
        chk("late_ready_busy", busy, 0);
        chk("late_ready_dmem_req", dmem_req, 0);
        chk("late_ready_retire", retire, 0);
        repeat (2) @(negedge clock);
        chk("stays_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #600000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation did not complete (retired=%0d)", n_retired);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the BeeF core. It fetches one 9-bit instruction at a time and holds it for `instruction_decode`. It samples the decoder's `address_select`/`alu_select`, then sequences the data-memory read, the ALU/pointer execute step and the write-back. It also owns the program counter and resolves the CBF branch.

## Interface
- `PC_WIDTH`, 8, program counter / instruction address width.
- `clock` input 1: single core clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: leave IDLE and begin fetching at current `pc`.
- `halt_req` input 1: stop at next instruction boundary.
- `imem_addr` output PC_WIDTH: instruction address (= `pc`).
- `imem_req` output 1: instruction fetch request.
- `imem_valid` input 1: `imem_data` valid this cycle; completes fetch.
- `imem_data` input 9: fetched instruction.
- `instr` output 9: instruction register, drives `instruction_decode`.
- `address_select` input 3: from decoder, sampled in DECODE.
- `alu_select` input 3: from decoder, sampled in DECODE.
- `addr_sel` output 3: registered `address_select` to the address mux.
- `alu_sel` output 3: registered `alu_select` to the ALU mux.
- `dmem_req` output 1: data-memory access request.
- `dmem_we` output 1: 1 = write, 0 = read; valid while `dmem_req`.
- `dmem_ready` input 1: completes the current data access.
- `cell_zero` input 1: current cell value == 0 (for CBF).
- `branch_target` input PC_WIDTH: CBF target from the branch table.
- `alu_en` output 1: one-cycle execute strobe.
- `retire` output 1: one-cycle pulse as an instruction completes.
- `busy` output 1: state != IDLE.

## Operation
- States: IDLE, FETCH, DECODE, MEM, EXEC, WB.
- Reset values:
  - State IDLE.
  - `pc`, `instr`, `addr_sel`, `alu_sel` = 0.
  - `imem_req`, `dmem_req`, `dmem_we`, `alu_en`, `retire`, `busy` = 0.
- IDLE: `start`=1 → FETCH. `halt_req` is ignored here.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_valid`.
  - On `imem_valid`: `instr` ← `imem_data`, → DECODE.
- DECODE (1 cycle):
  - `addr_sel` ← `address_select`, `alu_sel` ← `alu_select`.
  - `alu_select` ∈ {0,1,2} → MEM. Any other value (3, 4–7) → EXEC.
- MEM:
  - `dmem_req`=1, `dmem_we`=0 until `dmem_ready`, then → EXEC.
- EXEC (1 cycle), `alu_en`=1, then by `alu_sel`:
  - 0 (INC/DEC) or 2 (PSH/POP) → WB.
  - 1 (MVR/MVL): pointer update only; `pc` ← `pc`+1, retire.
  - 3: if `instr` is CBF and `cell_zero`=1, `pc` ← `branch_target`; otherwise `pc` ← `pc`+1. Retire.
  - 4–7: treated as NOP; `pc` ← `pc`+1, retire.
- WB:
  - `dmem_req`=1, `dmem_we`=1 until `dmem_ready`.
  - Then `pc` ← `pc`+1, retire.
- Retire:
  - `retire` pulses for 1 cycle, coincident with the `pc` update edge.
  - Next state is IDLE if `halt_req`=1 that cycle, else FETCH.
- `pc` arithmetic is modulo 2^PC_WIDTH: `pc`=2^PC_WIDTH−1 plus 1 → 0.
- `reset` mid-operation overrides everything: next cycle is IDLE with all reset values. The pending memory request is dropped, with no write completion required.
- `imem_valid`/`dmem_ready` arriving outside their own request state are ignored.

## Timing
- Handshake rule: a request is held ≥1 cycle and ends in the cycle its valid/ready is sampled high. A same-cycle response is legal, so zero-wait memory costs 1 cycle per access.
- Instruction latency with zero-wait memory, cycles from FETCH entry to `retire`:
  - INC/DEC/PSH/POP: 5.
  - MVR/MVL: 4.
  - CBF/NOP: 3.
- Each memory wait cycle adds exactly 1 cycle.
- `alu_en` is asserted only in EXEC, exactly once per instruction.
- `busy` drops the cycle after a halting retire.

## Test plan
- Reset, then `start` with `pc`=0 and INC at address 0, zero-wait memory:
  - `imem_req` 1 cycle, then DECODE.
  - `dmem_req`/`dmem_we`=0, then `alu_en`, then `dmem_we`=1.
  - `retire` on cycle 5; `pc`=1.
- MVR followed by NOP: retires 4 and 3 cycles apart; `dmem_req` never asserted with `dmem_we`=1.
- CBF with `cell_zero`=1, `branch_target`=0x40 → `pc`=0x40. Repeat with `cell_zero`=0 → `pc`=`pc`+1.
- `dmem_ready` held low 3 cycles during WB: `dmem_req`/`dmem_we` stay high and stable for 4 cycles, INC retires on cycle 8, `pc` advances exactly once.
- `pc`=0xFF with PC_WIDTH=8, NOP: `pc` wraps to 0x00. `halt_req`=1 at that retire → IDLE, `busy`=0 next cycle.
- `reset` asserted during MEM with `dmem_req`=1: next cycle all outputs are 0 and state is IDLE. A late `dmem_ready` is ignored.
